control_flow_unit_l7: RTL and testbench
=======================================

# control_flow_unit_l7

Parametrised, buffered execute unit for conditional branches, JAL and JALR. It sits between decode/issue and writeback, alongside the other execute units. It holds up to `p_depth` in-order operations and resolves the oldest one. It raises a one-cycle squash for taken branches and for every JALR, using a computed target. It also drops its own younger buffered operations when an older squash arrives, whether raised by itself or by another unit.

## Interface

Reset is synchronous and active-high on `rst`, sampled on the rising edge of `clk`.

Parameters:

- `p_seq_num_bits`, 5: sequence-number width.
- `p_phys_addr_bits`, 6: physical-register index width.
- `p_depth`, 2: buffer entries. Legal range is 1..16.

Ports:

- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `D`  D__XIntf.X_intf  carries `val`/`rdy`, `pc`[32], `seq_num`, `op1`/`op2`/`op3`[32], `waddr`[5], `uop`, `preg`, `ppreg`. `op3` is the immediate.
- `W`  X__WIntf.X_intf  carries `val`/`rdy`, `pc`, `seq_num`, `waddr`, `wdata`[32], `wen`, `preg`, `ppreg`.
- `squash_out`  SquashNotif.pub  carries `val`, `target`[32], `seq_num`. This is the squash raised by this unit.
- `squash_in`  SquashNotif.sub  carries `val`, `seq_num`. This is the arbitrated global squash from any unit, including this one.

## Operation

- **Buffer and enqueue.**
  - The buffer is an in-order circular queue. The head is the oldest entry.
  - `D_xfer` = `D.val & D.rdy`.
  - `D.rdy` = !full. There is no same-cycle pass-through of a dequeue into `D.rdy`.
- **Resolution at the head.** Only the head entry resolves.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU: taken per RISC-V rules. BLT and BGE compare signed; BLTU and BGEU compare unsigned.
  - Target = `pc + imm`, modulo 2^32.
  - JAL: never squashes, because decode already redirected.
  - JALR: always squashes. Target = `(op1 + imm) & ~32'h1`.
  - Any other uop: `W.val` still asserts, with `wen`=0 and no squash.
- **Writeback fields.**
  - `W.wen` = 1 for JAL and JALR, 0 for branches.
  - `W.wdata` = `pc + 4`, modulo 2^32.
  - All other `W` fields pass through from the head.
- **Own squash.**
  - Each entry carries a `sent` bit, cleared on enqueue.
  - `squash_out.val` = head valid & (taken | JALR) & !sent & !head_killed.
  - `sent` sets at the end of that cycle, so each entry squashes exactly once.
  - In the same edge, every entry behind the head is invalidated, as is any entry being enqueued that cycle. The head itself is kept.
- **External squash.**
  - `younger(a,b)` = (a − b) mod 2^`p_seq_num_bits` lies in [1, 2^(`p_seq_num_bits`−1)).
  - When `squash_in.val` is high:
    - Every valid entry with `younger(entry.seq_num, squash_in.seq_num)` is invalidated at the edge.
    - A same-cycle `D` enqueue meeting the same test is discarded.
  - `head_killed` is combinational and forces `W.val`=0 and `squash_out.val`=0 in that cycle.
- **Dequeue.** On `W.val & W.rdy`, the head pops, and the next entry becomes the head in the following cycle.

## Timing

- **Reset values:** queue empty, all `sent` bits 0, `D.rdy`=1, `W.val`=0, `squash_out.val`=0. `rst` mid-operation discards all entries at that edge.
- **Latency:** an enqueued operation is at the head and drives `W.val` the cycle after `D_xfer` if the queue was empty. Squash is raised in that same cycle.
- **Holds:** `W` fields are stable while `W.val & !W.rdy`, unless a kill occurs. `squash_out` is a single pulse and is never re-asserted while the head stalls.
- **Simultaneous pop and push when full:** not permitted, since `D.rdy`=0.
- **Simultaneous pop and push otherwise:** both happen, and the count is unchanged.
- **Simultaneous own and external squash:**
  - If `squash_in.seq_num` is older than the head, or equal to the head's, the head is killed or kept by the `younger` test only. The own squash is suppressed only if the head is killed.
  - If `squash_in.seq_num` is younger than the head, the own squash still issues and both flushes apply.
- **Pointer wrap:** read and write pointers wrap modulo `p_depth`. Full/empty is tracked with a separate count register of width `$clog2(p_depth+1)`.

## Structure

- **UArch (shared package):** holds the `rv_uop` encoding and a new `seq_younger(a,b,bits)` function, which other units' squash filters reuse.
- **Local packed entry struct:** `val`, `sent`, `pc`, `seq_num`, `op1`, `op2`, `imm`, `waddr`, `uop`, `preg`, `ppreg`.
- **Sub-module `squashable_fifo`:** a parametrised circular queue with push, pop, a per-entry kill mask, and a head output. The resolution logic and the kill-mask generation stay in the top level.

## Test plan

- **Not-taken branch:** BEQ with op1=5, op2=6, pc=0x100 → no squash; `W.val` in cycle +1, `wen`=0.
- **Taken branch flushes followers:** BNE with op1=1, op2=2, pc=0x200, imm=0x40, seq 3, followed by two queued ops (seq 4 and 5) → one-cycle `squash_out` with target 0x240 and seq 3. Seq 4 and 5 are gone. Seq 3 is held under `W.rdy`=0 for 3 cycles with no repeat squash.
- **JALR target and writeback:** JALR with op1=0x1001, imm=4, pc=0x300 → squash target 0x1004, `W.wdata`=0x304, `wen`=1. JAL at pc=0xFFFFFFFC → `wdata`=0x0, no squash.
- **Signed versus unsigned compare:** op1=0xFFFFFFFF, op2=1 → BLT taken, BLTU not taken; BGE not taken, BGEU taken.
- **External squash with wrap-around:** queue holds seq 30, 31, 0 (5-bit) and `squash_in` arrives with seq 31 → only seq 0 is dropped. With `squash_in` seq 29 instead, all three are dropped, `W.val`=0 that cycle, and any own squash is suppressed.
- **Backpressure and reset:** with `p_depth`=4, fill to 4 entries → `D.rdy`=0. Assert `rst` for one cycle → empty, `D.rdy`=1, `W.val`=0.

Source files
------------

// File: rtl/control_flow_unit_l7_pkg.sv
// rtl/control_flow_unit_l7_pkg.sv - shared uop encoding and sequence-age helper
// Purpose: rv_uop encoding used by the execute units, plus seq_younger(), which
//          every unit's squash filter uses to compare wrapping sequence numbers.
// Ports:   none (package)
package control_flow_unit_l7_pkg;

    localparam int c_xlen          = 32;
    localparam int c_arch_reg_bits = 5;

    typedef enum logic [3:0] {
        UOP_NOP  = 4'd0,
        UOP_BEQ  = 4'd1,
        UOP_BNE  = 4'd2,
        UOP_BLT  = 4'd3,
        UOP_BGE  = 4'd4,
        UOP_BLTU = 4'd5,
        UOP_BGEU = 4'd6,
        UOP_JAL  = 4'd7,
        UOP_JALR = 4'd8,
        UOP_ALU  = 4'd9
    } rv_uop_e;

    // a is younger than b when (a - b) mod 2^bits lies in [1, 2^(bits-1)).
    // Operands are zero-extended by the caller; only the low 'bits' are used.
    function automatic logic seq_younger(input logic [31:0] a, input logic [31:0] b,
                                         input int bits);
        logic [31:0] mask;
        logic [31:0] diff;
        mask = (32'd1 << bits) - 32'd1;
        diff = (a - b) & mask;
        return (diff != 32'd0) && (diff < (32'd1 << (bits - 1)));
    endfunction

endpackage

// File: rtl/control_flow_unit_l7_if.sv
// rtl/control_flow_unit_l7_if.sv - issue, writeback and squash interfaces
// Purpose: D__XIntf (issue into an execute unit), X__WIntf (execute to
//          writeback) and SquashNotif (squash broadcast).
// Ports:   D__XIntf    val/rdy, pc, seq_num, op1/op2/op3, waddr, uop, preg, ppreg
//          X__WIntf    val/rdy, pc, seq_num, waddr, wdata, wen, preg, ppreg
//          SquashNotif val, target, seq_num
interface D__XIntf
    import control_flow_unit_l7_pkg::*;
#(
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
);
    logic                        val;
    logic                        rdy;
    logic [31:0]                 pc;
    logic [p_seq_num_bits-1:0]   seq_num;
    logic [31:0]                 op1;
    logic [31:0]                 op2;
    logic [31:0]                 op3;
    logic [4:0]                  waddr;
    rv_uop_e                     uop;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;

    modport X_intf (input val, pc, seq_num, op1, op2, op3, waddr, uop, preg, ppreg,
                    output rdy);
    modport D_intf (output val, pc, seq_num, op1, op2, op3, waddr, uop, preg, ppreg,
                    input rdy);
endinterface

interface X__WIntf #(
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
);
    logic                        val;
    logic                        rdy;
    logic [31:0]                 pc;
    logic [p_seq_num_bits-1:0]   seq_num;
    logic [4:0]                  waddr;
    logic [31:0]                 wdata;
    logic                        wen;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;

    modport X_intf (output val, pc, seq_num, waddr, wdata, wen, preg, ppreg,
                    input rdy);
    modport W_intf (input val, pc, seq_num, waddr, wdata, wen, preg, ppreg,
                    output rdy);
endinterface

interface SquashNotif #(
    parameter int p_seq_num_bits = 5
);
    logic                      val;
    logic [31:0]               target;
    logic [p_seq_num_bits-1:0] seq_num;

    modport pub (output val, target, seq_num);
    modport sub (input val, seq_num);
endinterface

// File: rtl/control_flow_unit_l7_squashable_fifo.sv
// rtl/control_flow_unit_l7_squashable_fifo.sv - in-order circular queue with per-entry kill
// Purpose: holds in-order entries; the owner supplies a kill mask in logical
//          order (bit 0 = head) and the queue keeps the surviving prefix.
// Ports:   clk, rst            clock, synchronous active-high reset
//          push, push_data     enqueue behind the surviving entries
//          pop                 drop the head (only when the head is not killed)
//          head_wr_en/_data    rewrite the head in place (used for the sent bit)
//          kill_mask           logical-order kill request
//          q_valid, q_tag      logical-order occupancy and low tag bits
//          head_data, full     head entry and full flag
module squashable_fifo #(
    parameter int p_width    = 8,
    parameter int p_depth    = 2,
    parameter int p_tag_bits = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic [p_width-1:0]                   push_data,
    input  logic                                 pop,
    input  logic                                 head_wr_en,
    input  logic [p_width-1:0]                   head_wr_data,
    input  logic [p_depth-1:0]                   kill_mask,
    output logic [p_depth-1:0]                   q_valid,
    output logic [p_depth-1:0][p_tag_bits-1:0]   q_tag,
    output logic [p_width-1:0]                   head_data,
    output logic                                 full
);
    localparam int c_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int c_cnt_bits = $clog2(p_depth + 1);

    logic [p_width-1:0]    mem [p_depth];
    logic [c_ptr_bits-1:0] rd_ptr;
    logic [c_cnt_bits-1:0] count_q;
    logic [c_cnt_bits-1:0] kept;
    logic [c_ptr_bits-1:0] slot [p_depth];

    // base < p_depth and off <= p_depth, so one conditional subtract wraps.
    function automatic logic [c_ptr_bits-1:0] wrap_add(input logic [c_ptr_bits-1:0] base,
                                                       input logic [c_cnt_bits-1:0] off);
        int s;
        s = int'(base) + int'(off);
        if (s >= p_depth) s = s - p_depth;
        return c_ptr_bits'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < p_depth; i++) begin
            slot[i]    = wrap_add(rd_ptr, c_cnt_bits'(i));
            q_valid[i] = c_cnt_bits'(i) < count_q;
            q_tag[i]   = mem[slot[i]][p_tag_bits-1:0];
        end
    end

    // Kills always hit a younger suffix, so the surviving set is the prefix up
    // to the first killed entry; the write position simply follows it.
    always_comb begin
        logic alive;
        alive = 1'b1;
        kept  = '0;
        for (int i = 0; i < p_depth; i++) begin
            if (alive && q_valid[i] && !kill_mask[i]) begin
                kept = kept + c_cnt_bits'(1);
            end else begin
                alive = 1'b0;
            end
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = count_q == c_cnt_bits'(p_depth);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (head_wr_en) mem[rd_ptr] <= head_wr_data;
            if (push) mem[wrap_add(rd_ptr, kept)] <= push_data;
            if (pop) rd_ptr <= wrap_add(rd_ptr, c_cnt_bits'(1));
            count_q <= kept - c_cnt_bits'(pop) + c_cnt_bits'(push);
        end
    end

endmodule

// File: rtl/control_flow_unit_l7.sv
// rtl/control_flow_unit_l7.sv - buffered branch/JAL/JALR execute unit
// Purpose: queues up to p_depth in-order control-flow ops, resolves the head,
//          writes back the link value and raises a one-shot squash for taken
//          branches and every JALR; filters its queue on any older squash.
// Ports:   clk, rst    clock, synchronous active-high reset
//          D           issue input (op3 is the immediate)
//          W           writeback output
//          squash_out  squash raised by this unit
//          squash_in   arbitrated global squash
module control_flow_unit_l7
    import control_flow_unit_l7_pkg::*;
#(
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6,
    parameter int p_depth          = 2
) (
    input  logic           clk,
    input  logic           rst,
    D__XIntf.X_intf        D,
    X__WIntf.X_intf        W,
    SquashNotif.pub        squash_out,
    SquashNotif.sub        squash_in
);

    // seq_num sits in the low bits so the queue can expose it as the tag.
    typedef struct packed {
        logic                        val;
        logic                        sent;
        logic [31:0]                 pc;
        logic [31:0]                 op1;
        logic [31:0]                 op2;
        logic [31:0]                 imm;
        logic [4:0]                  waddr;
        rv_uop_e                     uop;
        logic [p_phys_addr_bits-1:0] preg;
        logic [p_phys_addr_bits-1:0] ppreg;
        logic [p_seq_num_bits-1:0]   seq_num;
    } entry_t;

    localparam int c_entry_bits = $bits(entry_t);

    logic [p_depth-1:0]                     q_valid;
    logic [p_depth-1:0][p_seq_num_bits-1:0] q_tag;
    logic [c_entry_bits-1:0]                head_data;
    logic                                   full;
    entry_t                                 head;
    entry_t                                 push_entry;
    entry_t                                 head_sent;
    logic [p_depth-1:0]                     kill_ext;
    logic [p_depth-1:0]                     kill_mask;
    logic                                   head_valid;
    logic                                   head_killed;
    logic                                   taken;
    logic                                   is_jal;
    logic                                   is_jalr;
    logic                                   own_squash;
    logic                                   d_xfer;
    logic                                   d_killed;
    logic                                   push;
    logic                                   pop;

    assign head       = entry_t'(head_data);
    assign head_valid = q_valid[0] & head.val;
    assign is_jal     = head.uop == UOP_JAL;
    assign is_jalr    = head.uop == UOP_JALR;

    always_comb begin
        taken = 1'b0;
        case (head.uop)
            UOP_BEQ:  taken = head.op1 == head.op2;
            UOP_BNE:  taken = head.op1 != head.op2;
            UOP_BLT:  taken = $signed(head.op1) <  $signed(head.op2);
            UOP_BGE:  taken = $signed(head.op1) >= $signed(head.op2);
            UOP_BLTU: taken = head.op1 <  head.op2;
            UOP_BGEU: taken = head.op1 >= head.op2;
            default:  taken = 1'b0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < p_depth; i++) begin
            kill_ext[i] = squash_in.val & q_valid[i]
                        & seq_younger(32'(q_tag[i]), 32'(squash_in.seq_num), p_seq_num_bits);
        end
    end

    assign head_killed = kill_ext[0];
    assign own_squash  = head_valid & (taken | is_jalr) & ~head.sent & ~head_killed;

    // Own squash keeps the head and drops everything behind it.
    assign kill_mask = kill_ext | ({p_depth{own_squash}} & ~p_depth'(1));

    assign d_xfer   = D.val & D.rdy;
    assign d_killed = own_squash
                    | (squash_in.val
                       & seq_younger(32'(D.seq_num), 32'(squash_in.seq_num), p_seq_num_bits));
    assign push     = d_xfer & ~d_killed;
    assign pop      = W.val & W.rdy;

    always_comb begin
        push_entry         = '0;
        push_entry.val     = 1'b1;
        push_entry.sent    = 1'b0;
        push_entry.pc      = D.pc;
        push_entry.op1     = D.op1;
        push_entry.op2     = D.op2;
        push_entry.imm     = D.op3;
        push_entry.waddr   = D.waddr;
        push_entry.uop     = D.uop;
        push_entry.preg    = D.preg;
        push_entry.ppreg   = D.ppreg;
        push_entry.seq_num = D.seq_num;
    end

    always_comb begin
        head_sent      = head;
        head_sent.sent = 1'b1;
    end

    squashable_fifo #(
        .p_width    (c_entry_bits),
        .p_depth    (p_depth),
        .p_tag_bits (p_seq_num_bits)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_data    (push_entry),
        .pop          (pop),
        .head_wr_en   (own_squash & ~pop),
        .head_wr_data (head_sent),
        .kill_mask    (kill_mask),
        .q_valid      (q_valid),
        .q_tag        (q_tag),
        .head_data    (head_data),
        .full         (full)
    );

    assign D.rdy   = ~full;

    assign W.val     = head_valid & ~head_killed;
    assign W.pc      = head.pc;
    assign W.seq_num = head.seq_num;
    assign W.waddr   = head.waddr;
    assign W.wdata   = head.pc + 32'd4;
    assign W.wen     = is_jal | is_jalr;
    assign W.preg    = head.preg;
    assign W.ppreg   = head.ppreg;

    assign squash_out.val     = own_squash;
    assign squash_out.target  = is_jalr ? ((head.op1 + head.imm) & ~32'h1)
                                        : (head.pc + head.imm);
    assign squash_out.seq_num = head.seq_num;

endmodule

// File: tb/tb_control_flow_unit_l7.sv
// tb/tb_control_flow_unit_l7.sv - self-checking bench for control_flow_unit_l7
module tb_control_flow_unit_l7;
    import control_flow_unit_l7_pkg::*;

    localparam int c_depth = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    D__XIntf    #(.p_seq_num_bits(5), .p_phys_addr_bits(6)) d_if ();
    X__WIntf    #(.p_seq_num_bits(5), .p_phys_addr_bits(6)) w_if ();
    SquashNotif #(.p_seq_num_bits(5)) sq_out_if ();
    SquashNotif #(.p_seq_num_bits(5)) sq_in_if ();

    control_flow_unit_l7 #(
        .p_seq_num_bits   (5),
        .p_phys_addr_bits (6),
        .p_depth          (c_depth)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .D          (d_if),
        .W          (w_if),
        .squash_out (sq_out_if),
        .squash_in  (sq_in_if)
    );

    typedef struct {
        logic [31:0] pc, op1, op2, imm;
        logic [4:0]  seq, waddr;
        rv_uop_e     uop;
        logic [5:0]  preg, ppreg;
        bit          sent;
    } op_t;

    op_t mq[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    logic [31:0] obs_drdy, obs_wval, obs_wdata, obs_wen, obs_wseq, obs_sqv, obs_target, obs_sqseq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_younger(input logic [4:0] a, input logic [4:0] b);
        int d;
        d = (int'(a) - int'(b) + 32) % 32;
        return d >= 1 && d < 16;
    endfunction

    function automatic bit m_taken(input op_t o);
        case (o.uop)
            UOP_BEQ:  return o.op1 == o.op2;
            UOP_BNE:  return o.op1 != o.op2;
            UOP_BLT:  return $signed(o.op1) <  $signed(o.op2);
            UOP_BGE:  return $signed(o.op1) >= $signed(o.op2);
            UOP_BLTU: return o.op1 <  o.op2;
            UOP_BGEU: return o.op1 >= o.op2;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic op_t mk(input rv_uop_e u, input logic [31:0] pc, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm, input logic [4:0] seq);
        op_t o;
        o.uop = u; o.pc = pc; o.op1 = a; o.op2 = b; o.imm = imm; o.seq = seq;
        o.waddr = 5'd7 + seq; o.preg = 6'd33 + 6'(seq); o.ppreg = 6'd2 + 6'(seq); o.sent = 1'b0;
        return o;
    endfunction

    // One clock: drive at the falling edge, compare against the queue model,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input bit dv, input op_t op, input bit wrdy, input bit sqv,
                        input logic [4:0] sqs);
        bit exp_rdy, hk, exp_wv, exp_sq, pop, push;
        logic [31:0] tgt;
        op_t nq[$];
        @(negedge clk);
        d_if.val = dv; d_if.pc = op.pc; d_if.seq_num = op.seq; d_if.op1 = op.op1;
        d_if.op2 = op.op2; d_if.op3 = op.imm; d_if.waddr = op.waddr; d_if.uop = op.uop;
        d_if.preg = op.preg; d_if.ppreg = op.ppreg;
        w_if.rdy = wrdy; sq_in_if.val = sqv; sq_in_if.seq_num = sqs;
        #1;
        exp_rdy = mq.size() < c_depth;
        hk      = mq.size() > 0 && sqv && m_younger(mq[0].seq, sqs);
        exp_wv  = mq.size() > 0 && !hk;
        exp_sq  = exp_wv && (m_taken(mq[0]) || mq[0].uop == UOP_JALR) && !mq[0].sent;
        obs_drdy = 32'(d_if.rdy); obs_wval = 32'(w_if.val); obs_wdata = w_if.wdata;
        obs_wen = 32'(w_if.wen); obs_wseq = 32'(w_if.seq_num); obs_sqv = 32'(sq_out_if.val);
        obs_target = sq_out_if.target; obs_sqseq = 32'(sq_out_if.seq_num);
        check("d_rdy", obs_drdy, 32'(exp_rdy));
        check("w_val", obs_wval, 32'(exp_wv));
        check("sq_val", obs_sqv, 32'(exp_sq));
        if (exp_wv) begin
            check("w_pc", w_if.pc, mq[0].pc);
            check("w_seq", obs_wseq, 32'(mq[0].seq));
            check("w_waddr", 32'(w_if.waddr), 32'(mq[0].waddr));
            check("w_wdata", obs_wdata, mq[0].pc + 32'd4);
            check("w_wen", obs_wen, 32'(mq[0].uop == UOP_JAL || mq[0].uop == UOP_JALR));
            check("w_pregs", {20'd0, w_if.preg, w_if.ppreg}, {20'd0, mq[0].preg, mq[0].ppreg});
        end
        if (exp_sq) begin
            tgt = (mq[0].uop == UOP_JALR) ? ((mq[0].op1 + mq[0].imm) & 32'hFFFF_FFFE)
                                          : (mq[0].pc + mq[0].imm);
            check("sq_target", obs_target, tgt);
            check("sq_seq", obs_sqseq, 32'(mq[0].seq));
        end
        pop  = exp_wv && wrdy;
        push = dv && exp_rdy && !exp_sq && !(sqv && m_younger(op.seq, sqs));
        foreach (mq[i]) begin
            if (!(sqv && m_younger(mq[i].seq, sqs)) && !(exp_sq && i > 0)) nq.push_back(mq[i]);
        end
        mq = nq;
        if (pop) void'(mq.pop_front());
        else if (exp_sq) mq[0].sent = 1'b1;
        if (push) begin
            op.sent = 1'b0;
            mq.push_back(op);
        end
    endtask

    op_t idle;
    rv_uop_e cmp_uop [4] = '{UOP_BLT, UOP_BLTU, UOP_BGE, UOP_BGEU};
    bit      cmp_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [4:0] next_seq;

    initial begin
        idle = mk(UOP_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        d_if.val = 1'b0; d_if.pc = '0; d_if.seq_num = '0; d_if.op1 = '0; d_if.op2 = '0;
        d_if.op3 = '0; d_if.waddr = '0; d_if.uop = UOP_NOP; d_if.preg = '0; d_if.ppreg = '0;
        w_if.rdy = 1'b0; sq_in_if.val = 1'b0; sq_in_if.seq_num = '0; sq_in_if.target = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        step(0, idle, 1, 0, 0);
        check("rst_d_rdy", obs_drdy, 1); check("rst_w_val", obs_wval, 0); check("rst_sq", obs_sqv, 0);

        // Not-taken BEQ
        step(1, mk(UOP_BEQ, 32'h100, 5, 6, 32'h10, 5'd1), 1, 0, 0);
        step(0, idle, 1, 0, 0);
        check("beq_wval", obs_wval, 1); check("beq_wen", obs_wen, 0); check("beq_sq", obs_sqv, 0);

        // Taken BNE behind a stalled op, with two followers queued
        step(1, mk(UOP_ALU, 32'h1F0, 0, 0, 0, 5'd2), 0, 0, 0);
        step(1, mk(UOP_BNE, 32'h200, 1, 2, 32'h40, 5'd3), 0, 0, 0);
        step(1, mk(UOP_ALU, 32'h204, 0, 0, 0, 5'd4), 0, 0, 0);
        step(1, mk(UOP_ALU, 32'h208, 0, 0, 0, 5'd5), 0, 0, 0);
        step(0, idle, 1, 0, 0);
        check("full_d_rdy", obs_drdy, 0);
        step(0, idle, 0, 0, 0);
        check("bne_sq", obs_sqv, 1); check("bne_target", obs_target, 32'h240);
        check("bne_sqseq", obs_sqseq, 3);
        for (int i = 0; i < 2; i++) begin
            step(0, idle, 0, 0, 0);
            check("bne_hold_sq", obs_sqv, 0); check("bne_hold_wval", obs_wval, 1);
        end
        step(0, idle, 1, 0, 0);
        step(0, idle, 1, 0, 0);
        check("bne_flushed", obs_wval, 0);

        // JALR and JAL link values
        step(1, mk(UOP_JALR, 32'h300, 32'h1001, 0, 4, 5'd6), 1, 0, 0);
        step(0, idle, 1, 0, 0);
        check("jalr_target", obs_target, 32'h1004); check("jalr_wdata", obs_wdata, 32'h304);
        check("jalr_wen", obs_wen, 1); check("jalr_sq", obs_sqv, 1);
        step(1, mk(UOP_JAL, 32'hFFFF_FFFC, 0, 0, 32'h20, 5'd7), 1, 0, 0);
        step(0, idle, 1, 0, 0);
        check("jal_wdata", obs_wdata, 32'h0); check("jal_sq", obs_sqv, 0); check("jal_wen", obs_wen, 1);

        // Signed versus unsigned compares
        for (int i = 0; i < 4; i++) begin
            step(1, mk(cmp_uop[i], 32'h400, 32'hFFFF_FFFF, 1, 8, 5'(8 + i)), 1, 0, 0);
            step(0, idle, 1, 0, 0);
            check("cmp_sq", obs_sqv, 32'(cmp_exp[i]));
        end

        // External squash across the sequence wrap
        step(1, mk(UOP_ALU, 32'h500, 0, 0, 0, 5'd30), 0, 0, 0);
        step(1, mk(UOP_ALU, 32'h504, 0, 0, 0, 5'd31), 0, 0, 0);
        step(1, mk(UOP_ALU, 32'h508, 0, 0, 0, 5'd0), 0, 0, 0);
        step(0, idle, 0, 1, 5'd31);
        check("wrap_head_kept", obs_wval, 1);
        step(0, idle, 1, 0, 0); check("wrap_seq30", obs_wseq, 30);
        step(0, idle, 1, 0, 0); check("wrap_seq31", obs_wseq, 31);
        step(0, idle, 1, 0, 0); check("wrap_seq0_gone", obs_wval, 0);

        step(1, mk(UOP_ALU, 32'h600, 0, 0, 0, 5'd28), 0, 0, 0);
        step(1, mk(UOP_BNE, 32'h604, 1, 2, 32'h80, 5'd30), 0, 0, 0);
        step(1, mk(UOP_ALU, 32'h608, 0, 0, 0, 5'd31), 0, 0, 0);
        step(1, mk(UOP_ALU, 32'h60C, 0, 0, 0, 5'd0), 0, 0, 0);
        step(0, idle, 1, 0, 0);
        step(0, idle, 0, 1, 5'd29);
        check("ext_kill_wval", obs_wval, 0); check("ext_kill_sq", obs_sqv, 0);
        step(0, idle, 1, 0, 0);
        check("ext_kill_empty", obs_wval, 0);

        // Backpressure then reset mid-operation
        for (int i = 0; i < 4; i++) step(1, mk(UOP_ALU, 32'h700, 0, 0, 0, 5'(1 + i)), 0, 0, 0);
        step(0, idle, 0, 0, 0);
        check("bp_d_rdy", obs_drdy, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mq.delete();
        step(0, idle, 1, 0, 0);
        check("rst2_d_rdy", obs_drdy, 1); check("rst2_w_val", obs_wval, 0);

        // Randomised traffic
        next_seq = 5'd10;
        for (int c = 0; c < 2000; c++) begin
            op_t r;
            bit dv, wrdy, sqv, acc;
            logic [4:0] sqs;
            r.uop = rv_uop_e'($urandom_range(0, 9));
            r.pc = $urandom; r.op1 = $urandom;
            r.op2 = ($urandom_range(0, 2) == 0) ? r.op1 : $urandom;
            r.imm = $urandom; r.seq = next_seq; r.waddr = 5'($urandom);
            r.preg = 6'($urandom); r.ppreg = 6'($urandom); r.sent = 1'b0;
            dv   = ($urandom_range(0, 2) != 0)
                && !(mq.size() > 0 && 5'(next_seq - mq[0].seq) >= 5'd12);
            wrdy = $urandom_range(0, 3) != 0;
            sqv  = $urandom_range(0, 7) == 0;
            sqs  = next_seq - 5'($urandom_range(1, 5));
            acc  = dv && mq.size() < c_depth;
            step(dv, r, wrdy, sqv, sqs);
            if (acc) next_seq = next_seq + 5'd1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
